// File: rtl/multicycle_div_if.sv
// multicycle_div_if: operand/strobe/result bundle for the 32-bit multicycle divider.
//   master: drives data_operandA, data_operandB, ctrl_DIV; receives the results
//   slave : the divider; receives operands/strobe, drives data_result,
//           data_exception, data_resultRDY
interface multicycle_div_if;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  modport master (
    output data_operandA, data_operandB, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_DIV,
    output data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/multicycle_div.sv
// multicycle_div: signed 32-bit restoring divider, one quotient bit per cycle.
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : multicycle_div_if.slave
//     data_operandA/B : dividend/divisor, latched only on a ctrl_DIV edge
//     ctrl_DIV        : start strobe; restarts from any state
//     data_result     : signed quotient (truncated toward zero), held
//     data_exception  : divide-by-zero flag, valid with data_resultRDY
//     data_resultRDY  : one-cycle completion pulse, 33 cycles after start
module multicycle_div (
  input logic              clock,
  input logic              reset,
  multicycle_div_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [32:0] rem;     // partial remainder
  logic [31:0] quo;     // holds |A| at start; quotient bits shift in from the LSB
  logic [31:0] dvs;     // |B|
  logic        neg;     // quotient sign
  logic        dz;      // latched divisor was zero
  logic [5:0]  cnt;     // iterations done, 0..32

  logic [32:0] shifted;
  logic        ge;
  logic [32:0] rem_nxt;
  logic [31:0] q_fin;

  function automatic logic [31:0] mag(input logic [31:0] v);
    // 0x80000000 maps onto itself, which is the correct unsigned magnitude
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  // One restoring step: bring down the next dividend bit and try a subtract.
  // rem < dvs <= 2^31 always holds, so the shifted value fits in 33 bits.
  always_comb begin
    shifted = {rem[31:0], quo[31]};
    ge      = (shifted >= {1'b0, dvs});
    rem_nxt = ge ? (shifted - {1'b0, dvs}) : shifted;
    q_fin   = dz ? 32'd0 : (neg ? (~quo + 32'd1) : quo);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      rem                <= '0;
      quo                <= '0;
      dvs                <= '0;
      neg                <= 1'b0;
      dz                 <= 1'b0;
      cnt                <= '0;
      bus.data_result    <= '0;
      bus.data_exception <= 1'b0;
      bus.data_resultRDY <= 1'b0;
    end else if (bus.ctrl_DIV) begin
      // start wins in every state; an in-flight op is dropped without a pulse
      state              <= BUSY;
      rem                <= '0;
      quo                <= mag(bus.data_operandA);
      dvs                <= mag(bus.data_operandB);
      neg                <= bus.data_operandA[31] ^ bus.data_operandB[31];
      dz                 <= (bus.data_operandB == 32'd0);
      cnt                <= '0;
      bus.data_resultRDY <= 1'b0;
    end else begin
      case (state)
        BUSY: begin
          if (cnt == 6'd32) begin
            bus.data_result    <= q_fin;
            bus.data_exception <= dz;
            bus.data_resultRDY <= 1'b1;
            state              <= DONE;
          end else begin
            rem <= rem_nxt;
            quo <= {quo[30:0], ge};
            cnt <= cnt + 6'd1;
          end
        end
        DONE: begin
          bus.data_resultRDY <= 1'b0;
          state              <= IDLE;
        end
        default: begin
          bus.data_resultRDY <= 1'b0;
          state              <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_div.sv
module tb_multicycle_div;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  multicycle_div_if bus();

  multicycle_div dut (.clock(clk), .reset(rst), .bus(bus));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_q(input logic [31:0] a, input logic [31:0] b);
    longint la, lb, q;
    if (b == 32'd0) return 32'd0;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    q  = la / lb;            // 64-bit: no overflow, truncates toward zero
    return q[31:0];
  endfunction

  logic [31:0] m_res, m_pend_res;
  logic        m_exc, m_pend_exc, m_rdy;
  int          m_cnt;        // edges left until completion, 0 = nothing pending
  logic        m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_res <= 32'd0; m_exc <= 1'b0; m_rdy <= 1'b0; m_cnt <= 0; m_valid <= 1'b1;
    end else if (bus.ctrl_DIV) begin
      m_pend_res <= ref_q(bus.data_operandA, bus.data_operandB);
      m_pend_exc <= (bus.data_operandB == 32'd0);
      m_cnt      <= 33;
      m_rdy      <= 1'b0;
    end else begin
      m_rdy <= (m_cnt == 1);
      if (m_cnt == 1) begin
        m_res <= m_pend_res;
        m_exc <= m_pend_exc;
      end
      if (m_cnt != 0) m_cnt <= m_cnt - 1;
    end
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endfunction

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model result", bus.data_result, m_res);
      chk("model exception", {31'd0, bus.data_exception}, {31'd0, m_exc});
      chk("model rdy", {31'd0, bus.data_resultRDY}, {31'd0, m_rdy});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_DIV      = 1'b1;
    @(negedge clk);
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;   // must be ignored while busy
    bus.data_operandB = $urandom;
  endtask

  // n = edges since the start edge when RDY is first seen (40 = timed out)
  task automatic wait_rdy(output int n);
    n = 0;
    while (!bus.data_resultRDY && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_div(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input logic exc);
    int n;
    start(a, b);
    wait_rdy(n);
    chk({nm, " latency"}, n, 33);
    chk({nm, " result"}, bus.data_result, exp);
    chk({nm, " exception"}, {31'd0, bus.data_exception}, {31'd0, exc});
    @(negedge clk);
    chk({nm, " rdy drop"}, {31'd0, bus.data_resultRDY}, 32'd0);
    chk({nm, " held"}, bus.data_result, exp);
  endtask

  function automatic logic [31:0] rnd_op();
    int s;
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: begin s = int'($urandom_range(0, 40)) - 20; return 32'(s); end
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [31:0] a, b;
    int mode;

    rst = 1'b1;
    bus.ctrl_DIV = 1'b0;
    bus.data_operandA = 32'd0;
    bus.data_operandB = 32'd0;

    // pin the model with hand-computed values
    chk("ref 100/7", ref_q(32'd100, 32'd7), 32'd14);
    chk("ref -100/7", ref_q(32'hFFFF_FF9C, 32'd7), 32'hFFFF_FFF2);
    chk("ref overflow", ref_q(32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    chk("ref 3/5", ref_q(32'd3, 32'd5), 32'd0);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset result", bus.data_result, 32'd0);
    chk("reset exception", {31'd0, bus.data_exception}, 32'd0);
    chk("reset rdy", {31'd0, bus.data_resultRDY}, 32'd0);

    do_div("100/7", 32'd100, 32'd7, 32'd14, 1'b0);
    do_div("-100/7", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0);
    do_div("100/-7", 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0);
    do_div("-100/-7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 1'b0);
    do_div("max/1", 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 1'b0);
    do_div("3/5", 32'd3, 32'd5, 32'd0, 1'b0);
    do_div("0/-9", 32'd0, 32'hFFFF_FFF7, 32'd0, 1'b0);
    do_div("7/0", 32'd7, 32'd0, 32'd0, 1'b1);
    do_div("overflow", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);

    // restart mid-operation: only the second op completes
    start(32'd1000, 32'd10);
    repeat (9) @(negedge clk);
    start(32'd50, 32'd5);
    wait_rdy(n);
    chk("restart latency", n, 33);
    chk("restart result", bus.data_result, 32'd10);

    // strobe held three edges: result is from the last one
    bus.data_operandA = 32'd1000; bus.data_operandB = 32'd10; bus.ctrl_DIV = 1'b1;
    @(negedge clk);
    bus.data_operandA = 32'd77;   bus.data_operandB = 32'd7;
    @(negedge clk);
    start(32'd81, 32'd9);
    wait_rdy(n);
    chk("held strobe latency", n, 33);
    chk("held strobe result", bus.data_result, 32'd9);
    @(negedge clk);

    // reset during busy
    start(32'd1000, 32'd10);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("busy reset result", bus.data_result, 32'd0);
    chk("busy reset rdy", {31'd0, bus.data_resultRDY}, 32'd0);
    do_div("9/3", 32'd9, 32'd3, 32'd3, 1'b0);

    // randomized traffic; the model checks every cycle
    for (int i = 0; i < 1200; i++) begin
      a = rnd_op();
      b = rnd_op();
      mode = $urandom_range(0, 5);
      start(a, b);
      if (mode == 0) begin
        repeat ($urandom_range(0, 31)) @(negedge clk);   // next start aborts this one
      end else if (mode == 1) begin
        repeat ($urandom_range(0, 31)) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else begin
        wait_rdy(n);
        chk("random latency", n, 33);
        chk("random result", bus.data_result, ref_q(a, b));
        // mode 2: next start lands in the DONE cycle
        if (mode > 2) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
